drive_cmd_json_tx: RTL and testbench

Sits directly downstream of the drive FSM and feeds the rover motor controller over the GPIO UART line. It takes the FSM's 4-bit drive_state and emits a fixed-length 28-byte JSON wheel-speed command, `{"T":1,"L":+0.50,"R":+0.50}` followed by LF, as 8N1 UART. A command goes out on every drive_state change, on an explicit resend request, and on a periodic heartbeat, so the motor board's watchdog never times out.

---
 rtl/drive_cmd_pkg.sv | 61 ++++++
 rtl/drive_cmd_json_tx_uart.sv | 55 +++++
 rtl/drive_cmd_json_tx.sv | 108 ++++++++++
 tb/tb_drive_cmd_json_tx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/drive_cmd_pkg.sv
// rtl/drive_cmd_pkg.sv - drive codes, JSON command template and field encoding for the motor UART link
package drive_cmd_pkg;

    localparam logic [3:0] STOP     = 4'd0;
    localparam logic [3:0] FWD      = 4'd1;
    localparam logic [3:0] REV      = 4'd2;
    localparam logic [3:0] SPIN_L   = 4'd3;
    localparam logic [3:0] SPIN_R   = 4'd4;
    localparam logic [3:0] VEER_L   = 4'd5;
    localparam logic [3:0] VEER_R   = 4'd6;
    localparam logic [3:0] FWD_SLOW = 4'd7;
    localparam logic [3:0] REV_SLOW = 4'd8;

    localparam int MSG_LEN   = 28;
    localparam int L_OFS     = 11;
    localparam int R_OFS     = 21;
    localparam int FIELD_LEN = 5;

    // Field bytes here are placeholders; msg_byte overlays the encoded L/R values.
    localparam logic [8*MSG_LEN-1:0] MSG_TEMPLATE =
        {"{\"T\":1,\"L\":+0.00,\"R\":+0.00}", 8'h0A};

    typedef struct packed {
        logic [8*FIELD_LEN-1:0] l;
        logic [8*FIELD_LEN-1:0] r;
    } fields_t;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    function automatic fields_t code_fields(input logic [3:0] code);
        fields_t f;
        case (code)
            FWD:      f = {"+0.50", "+0.50"};
            REV:      f = {"-0.50", "-0.50"};
            SPIN_L:   f = {"-0.30", "+0.30"};
            SPIN_R:   f = {"+0.30", "-0.30"};
            VEER_L:   f = {"+0.25", "+0.50"};
            VEER_R:   f = {"+0.50", "+0.25"};
            FWD_SLOW: f = {"+0.20", "+0.20"};
            REV_SLOW: f = {"-0.20", "-0.20"};
            default:  f = {"+0.00", "+0.00"};
        endcase
        return f;
    endfunction

    function automatic logic [7:0] msg_byte(input logic [3:0] code, input logic [4:0] idx);
        fields_t f;
        int i;
        f = code_fields(code);
        i = int'(idx);
        if (i >= L_OFS && i < L_OFS + FIELD_LEN)
            return f.l[8*(FIELD_LEN-1-(i-L_OFS)) +: 8];
        else if (i >= R_OFS && i < R_OFS + FIELD_LEN)
            return f.r[8*(FIELD_LEN-1-(i-R_OFS)) +: 8];
        else if (i < MSG_LEN)
            return MSG_TEMPLATE[8*(MSG_LEN-1-i) +: 8];
        else
            return 8'h0A;
    endfunction

endpackage

// File: rtl/drive_cmd_json_tx_uart.sv
// rtl/drive_cmd_json_tx_uart.sv - 8N1 LSB-first UART byte serializer with valid/ready input
module uart_tx_byte #(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       byte_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic          active;
    logic [CW-1:0] div_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    frame;
    logic          last;

    // Ready during the final stop-bit cycle lets the next byte start with no idle gap.
    assign last      = active && (div_cnt == CW'(DIV-1)) && (bit_cnt == 4'd9);
    assign ready     = !active || last;
    assign byte_done = last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            frame   <= '1;
            tx      <= 1'b1;
        end else if (valid && ready) begin
            frame   <= {1'b1, data};
            tx      <= 1'b0;
            active  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (last) begin
            active <= 1'b0;
            tx     <= 1'b1;
        end else if (active) begin
            if (div_cnt == CW'(DIV-1)) begin
                div_cnt <= '0;
                bit_cnt <= bit_cnt + 4'd1;
                tx      <= frame[0];
                frame   <= {1'b1, frame[8:1]};
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/drive_cmd_json_tx.sv
// rtl/drive_cmd_json_tx.sv - emits a JSON wheel-speed command over UART on state change, resend or heartbeat
module drive_cmd_json_tx
    import drive_cmd_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int HEARTBEAT_MS = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] drive_state,
    input  logic       send_req,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [3:0] sent_state
);

    localparam int DIV       = (CLK_HZ + BAUD/2) / BAUD;
    localparam int HB_CYCLES = CLK_HZ / 1000 * HEARTBEAT_MS;
    localparam int HW        = $clog2(HB_CYCLES + 1);

    state_t        state;
    logic          pending;
    logic [3:0]    snap;
    logic [4:0]    idx;
    logic [HW-1:0] hb_cnt;

    logic          hb_hit;
    logic          trigger;
    logic [4:0]    hand_idx;
    logic          byte_valid;
    logic          byte_ready;
    logic          byte_done;
    logic [7:0]    byte_data;

    assign hb_hit  = (hb_cnt == HW'(HB_CYCLES-1));
    assign trigger = (drive_state != sent_state) || pending || send_req || hb_hit;

    // idx is the byte in flight; the serializer is offered the one after it so bytes run back to back.
    assign hand_idx   = (state == LOAD) ? 5'd0 : idx + 5'd1;
    assign byte_valid = (state == LOAD) || ((state == SEND) && (idx != 5'(MSG_LEN-1)));
    assign byte_data  = msg_byte(snap, hand_idx);

    uart_tx_byte #(.DIV(DIV)) u_uart (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (byte_data),
        .valid     (byte_valid),
        .ready     (byte_ready),
        .tx        (tx),
        .byte_done (byte_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= 1'b1;
            snap       <= STOP;
            idx        <= '0;
            hb_cnt     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sent_state <= STOP;
        end else begin
            done <= 1'b0;
            if (send_req && state != IDLE)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (!hb_hit)
                        hb_cnt <= hb_cnt + 1'b1;
                    if (trigger) begin
                        snap    <= drive_state;
                        pending <= 1'b0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    idx   <= '0;
                    busy  <= 1'b1;
                    state <= SEND;
                end
                SEND: begin
                    if (byte_done) begin
                        if (idx == 5'(MSG_LEN-1)) begin
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            sent_state <= snap;
                            state      <= DONE;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                DONE: begin
                    hb_cnt <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_ready;
    assign unused_ready = byte_ready;

endmodule

// File: tb/tb_drive_cmd_json_tx.sv
// tb/tb_drive_cmd_json_tx.sv - scoreboard bench decoding the UART line against directed expected messages
module tb_drive_cmd_json_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] drive_state = 4'd0;
    logic       send_req = 1'b0;
    logic       tx, busy, done;
    logic [3:0] sent_state;

    int tests = 0, fails = 0, cyc = 0;
    int msg_starts = 0, msg_start_cyc = 0, mon_nbytes = 0;

    string      exp_q[$];
    logic [3:0] st_q[$];

    string M_STOP  = "{\"T\":1,\"L\":+0.00,\"R\":+0.00}";
    string M_FWD   = "{\"T\":1,\"L\":+0.50,\"R\":+0.50}";
    string M_REV   = "{\"T\":1,\"L\":-0.50,\"R\":-0.50}";
    string M_SPINL = "{\"T\":1,\"L\":-0.30,\"R\":+0.30}";
    string M_VEERL = "{\"T\":1,\"L\":+0.25,\"R\":+0.50}";

    drive_cmd_json_tx #(
        .CLK_HZ(1_152_000), .BAUD(115200), .HEARTBEAT_MS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .drive_state(drive_state), .send_req(send_req),
        .tx(tx), .busy(busy), .done(done), .sent_state(sent_state)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic expect_msg(input string m, input logic [3:0] s);
        exp_q.push_back(m);
        st_q.push_back(s);
    endtask

    task automatic wait_done(output int d);
        int n;
        n = 0;
        d = -1;
        while (d < 0 && n < 4000) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) d = cyc;
        end
        chk("done_seen", int'(d >= 0), 1);
    endtask

    task automatic wait_start(input int prev, output int s);
        int n;
        n = 0;
        while (msg_starts == prev && n < 3000) begin
            @(negedge clk);
            n++;
        end
        s = msg_start_cyc;
        chk("start_seen", int'(msg_starts != prev), 1);
    endtask

    task automatic wait_bytes(input int nb);
        int n;
        n = 0;
        while (mon_nbytes < nb && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("bytes_seen", int'(mon_nbytes >= nb), 1);
    endtask

    task automatic pulse_req();
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
    endtask

    // UART decoder: samples mid-bit at DIV=10, pops the expected message on LF.
    initial begin
        logic [7:0] b;
        logic       st0, stp, aborted;
        string      mbuf, e;
        mbuf = "";
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                aborted = 1'b0;
                if (mbuf.len() == 0) begin
                    msg_start_cyc = cyc;
                    msg_starts++;
                end
                repeat (5) begin @(negedge clk); if (rst_n !== 1'b1) aborted = 1'b1; end
                st0 = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (10) begin @(negedge clk); if (rst_n !== 1'b1) aborted = 1'b1; end
                    b[i] = tx;
                end
                repeat (10) begin @(negedge clk); if (rst_n !== 1'b1) aborted = 1'b1; end
                stp = tx;
                if (aborted) begin
                    mbuf = "";
                    mon_nbytes = 0;
                end else begin
                    chk("start_bit", int'(st0), 0);
                    chk("stop_bit", int'(stp), 1);
                    if (b == 8'h0A) begin
                        if (exp_q.size() == 0) begin
                            chk_str("unexpected_message", mbuf, "");
                        end else begin
                            e = exp_q.pop_front();
                            chk_str("message", mbuf, e);
                        end
                        mbuf = "";
                        mon_nbytes = 0;
                    end else begin
                        mbuf = {mbuf, $sformatf("%c", b)};
                        mon_nbytes++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (st_q.size() == 0) chk("unexpected_done", 1, 0);
                else                  chk("sent_state_at_done", int'(sent_state), int'(st_q.pop_front()));
            end
        end
    end

    initial begin
        int k, s, d0, d1, d2, d3, d4, d5, prev;

        repeat (5) @(negedge clk);
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_sent_state", int'(sent_state), 0);

        // Power-up STOP message from the pending flag
        expect_msg(M_STOP, 4'd0);
        prev = msg_starts;
        k = cyc;
        rst_n = 1'b1;
        wait_start(prev, s);
        chk("first_latency", s - k, 2);
        wait_bytes(2);
        chk("busy_mid_msg", int'(busy), 1);
        wait_done(d0);
        chk("msg_length_cycles", d0 - s, 2800);
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);

        // SPIN_L from idle
        repeat (5) @(negedge clk);
        expect_msg(M_SPINL, 4'd3);
        prev = msg_starts;
        k = cyc;
        drive_state = 4'd3;
        wait_start(prev, s);
        chk("change_latency", s - k, 2);
        wait_bytes(5);
        chk("sent_state_mid_msg", int'(sent_state), 0);
        wait_done(d1);

        // FWD with a mid-message change to REV
        repeat (5) @(negedge clk);
        expect_msg(M_FWD, 4'd1);
        drive_state = 4'd1;
        wait_bytes(5);
        expect_msg(M_REV, 4'd2);
        drive_state = 4'd2;
        wait_done(d1);
        prev = msg_starts;
        wait_start(prev, s);
        chk("back_to_back_gap", s - d1, 3);
        wait_done(d2);

        // Heartbeat repeats of FWD
        repeat (5) @(negedge clk);
        expect_msg(M_FWD, 4'd1);
        drive_state = 4'd1;
        wait_done(d3);
        expect_msg(M_FWD, 4'd1);
        prev = msg_starts;
        wait_start(prev, s);
        chk("heartbeat_gap_1", s - d3, 1154);
        wait_done(d4);
        expect_msg(M_FWD, 4'd1);
        prev = msg_starts;
        wait_start(prev, s);
        chk("heartbeat_gap_2", s - d4, 1154);
        wait_done(d5);

        // Code 12 encodes as STOP; three resend pulses yield one extra message
        repeat (5) @(negedge clk);
        expect_msg(M_STOP, 4'd12);
        drive_state = 4'd12;
        wait_bytes(3);
        pulse_req();
        wait_bytes(10);
        pulse_req();
        wait_bytes(20);
        pulse_req();
        expect_msg(M_STOP, 4'd12);
        wait_done(d0);
        wait_done(d1);
        prev = msg_starts;
        repeat (600) @(negedge clk);
        chk("no_extra_message", msg_starts - prev, 0);

        // send_req while idle is an immediate trigger
        expect_msg(M_STOP, 4'd12);
        prev = msg_starts;
        k = cyc;
        pulse_req();
        wait_start(prev, s);
        chk("send_req_latency", s - k, 2);
        wait_done(d0);

        // Reset in the middle of byte 3 of a VEER_L message
        repeat (5) @(negedge clk);
        drive_state = 4'd5;
        wait_bytes(3);
        repeat (40) @(negedge clk);
        chk("tx_before_reset", int'(tx), 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_tx", int'(tx), 1);
        chk("abort_busy", int'(busy), 0);
        drive_state = 4'd0;
        repeat (150) @(negedge clk);
        chk("abort_sent_state", int'(sent_state), 0);
        expect_msg(M_STOP, 4'd0);
        prev = msg_starts;
        k = cyc;
        rst_n = 1'b1;
        wait_start(prev, s);
        chk("post_reset_latency", s - k, 2);
        wait_done(d0);

        repeat (5) @(negedge clk);
        expect_msg(M_VEERL, 4'd5);
        drive_state = 4'd5;
        wait_done(d0);

        repeat (3) @(negedge clk);
        chk("msg_queue_empty", exp_q.size(), 0);
        chk("state_queue_empty", st_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
